sccb_cfg_sequencer: RTL
=======================

// Module: sccb_cfg_sequencer
// PURPOSE
//   Upstream stage of the SCCB transmitter. Walks an internal register table of {addr,value} pairs for
//   the OV7670 (device ID 0x42), issues one write per entry over a send/done handshake, and inserts
//   power-up, soft-reset and inter-write delays. Raises cfg_done when the camera is fully configured.
// PARAMETERS
//   REG_NUM      8'd8     number of table entries (index 0..REG_NUM-1); REG_NUM >= 1
//   PWR_DLY_CYC  500000   cycles to wait after rst_n release before the first write (20 ms @ 25 MHz)
//   RST_DLY_CYC  25000    extra wait after writing 0x80 to reg 0x12 (soft reset), 1 ms @ 25 MHz
//   GAP_CYC      16       idle cycles between a done pulse and the next send_en
//   TIMEOUT_CYC  32000    max cycles from send_en to done before retry (SCCB_TIMEOUT_EN only)
// PORTS
//   clk           in   1  system clock, 25 MHz
//   rst_n         in   1  asynchronous, active-low reset
//   cfg_start     in   1  one-cycle pulse: re-run the whole table (honoured only in FINISH)
//   sccb_done     in   1  one-cycle pulse from transmitter: current write finished
//   sccb_send_en  out  1  one-cycle pulse: start a write with sccb_addr/sccb_value
//   sccb_addr     out  8  register address of current entry
//   sccb_value    out  8  register data of current entry
//   cfg_index     out  8  index of the entry being written
//   cfg_busy      out  1  1 from reset release until FINISH is reached
//   cfg_done      out  1  1 while in FINISH
//   timeout_err   out  1  sticky: a write timed out at least once (tied 0 without SCCB_TIMEOUT_EN)
// BEHAVIOUR
//   Reset: state=PWR_WAIT, all counters 0, sccb_send_en=0, sccb_addr=0, sccb_value=0, cfg_index=0,
//     cfg_busy=1, cfg_done=0, timeout_err=0. Assertion mid-operation aborts immediately; the
//     transmitter is reset by the same rst_n.
//   Table: combinational case on cfg_index; entry 0 = {0x12,0x80} (soft reset); entries 1..REG_NUM-1
//     hold the team default register set; out-of-range index returns {0xFF,0xFF} (never sent).
//   FSM (all outputs registered):
//   - PWR_WAIT: count PWR_DLY_CYC cycles, then -> LOAD.
//   - LOAD: sccb_addr/sccb_value <= table[cfg_index]; -> SEND next cycle. Data stays stable until
//     the next LOAD.
//   - SEND: sccb_send_en=1 for exactly this one cycle; -> WAIT_DONE.
//   - WAIT_DONE: hold until sccb_done=1. If the entry was {0x12,0x80} -> RST_WAIT, else -> GAP.
//   - RST_WAIT: count RST_DLY_CYC cycles -> NEXT.   GAP: count GAP_CYC cycles -> NEXT.
//   - NEXT: if cfg_index==REG_NUM-1 -> FINISH, else cfg_index+1 and -> LOAD.
//   - FINISH: cfg_done=1, cfg_busy=0, cfg_index holds last value. On cfg_start: cfg_index=0,
//     cfg_done=0, cfg_busy=1, -> LOAD (power-up delay not repeated).
//   Boundaries:
//   - sccb_done outside WAIT_DONE is ignored.
//   - sccb_done coinciding with the SEND cycle is ignored; only done seen in WAIT_DONE counts.
//   - cfg_start outside FINISH is ignored.
//   - REG_NUM=1: single write, then FINISH.
//   - Delay counters reset to 0 on every state entry; a delay of N holds the state exactly N cycles.
//   Latency: done pulse -> next send_en = GAP_CYC + 3 cycles (WAIT_DONE exit, GAP, NEXT, LOAD, SEND).
// CONFIGURATION
//   SCCB_TIMEOUT_EN defined: in WAIT_DONE a counter runs from 0. On reaching TIMEOUT_CYC without done:
//     set timeout_err=1 (sticky until rst_n) and -> LOAD, retrying the same index. Retries are
//     unlimited; the counter clears on each SEND.
//   SCCB_TIMEOUT_EN undefined: no counter; WAIT_DONE waits forever; timeout_err tied 0.
// TESTING
//   1 Release rst_n; model done 100 cycles after each send_en -> first send_en exactly PWR_DLY_CYC+2
//     cycles after release with addr=0x12, value=0x80.
//   2 After entry 0 done -> next send_en RST_DLY_CYC+3 cycles later with cfg_index=1; other entries
//     are spaced GAP_CYC+3 cycles after done.
//   3 Full run with REG_NUM=8 -> exactly 8 send_en pulses, addr/value match table, then cfg_done=1
//     and cfg_busy=0.
//   4 Spurious done pulses in GAP/PWR_WAIT and cfg_start mid-run -> no extra send_en, cfg_index
//     unaffected. cfg_start in FINISH -> index 0 rewritten after 2 cycles.
//   5 Assert rst_n in WAIT_DONE of entry 3 -> all outputs return to reset values; the sequence
//     restarts from PWR_WAIT.
//   6 (SCCB_TIMEOUT_EN) Suppress done for entry 2 -> after TIMEOUT_CYC, timeout_err=1 and entry 2 is
//     resent; normal done then continues to FINISH.

Source files
------------

// File: rtl/sccb_cfg_sequencer.sv
// sccb_cfg_sequencer: walks the OV7670 register table and issues one SCCB write per entry.
// It inserts a power-up delay, a soft-reset settle delay and inter-write gaps.
// Optional macro SCCB_TIMEOUT_EN adds a per-write timeout with unlimited retries and a sticky
// timeout_err flag. Without it, WAIT_DONE waits forever and timeout_err is tied low.
// The delay parameters are assumed to be >= 1.
module sccb_cfg_sequencer #(
    parameter logic [7:0]  REG_NUM     = 8'd8,
    parameter int unsigned PWR_DLY_CYC = 500000,
    parameter int unsigned RST_DLY_CYC = 25000,
    parameter int unsigned GAP_CYC     = 16
`ifdef SCCB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 32000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic       sccb_done,
    output logic       sccb_send_en,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_value,
    output logic [7:0] cfg_index,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       timeout_err
);

    localparam logic [2:0] S_PWR_WAIT  = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RST_WAIT  = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam logic [2:0] S_NEXT      = 3'd6;
    localparam logic [2:0] S_FINISH    = 3'd7;

    localparam logic [31:0] RST_LAST = RST_DLY_CYC - 1;
    localparam logic [31:0] GAP_LAST = GAP_CYC - 1;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  value_q, value_d;
    logic        send_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] tbl_entry;
    logic        is_soft_rst;
    logic        counting;
    logic        timeout_hit;

`ifdef SCCB_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = TIMEOUT_CYC - 1;
    logic timeout_err_q;

    assign timeout_hit = (state_q == S_WAIT_DONE) && !sccb_done && (cnt_q == TO_LAST);
    assign counting    = (state_q == S_PWR_WAIT) || (state_q == S_RST_WAIT) ||
                         (state_q == S_GAP) || (state_q == S_WAIT_DONE);

    // Sticky timeout flag, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign counting    = (state_q == S_PWR_WAIT) || (state_q == S_RST_WAIT) ||
                         (state_q == S_GAP);
    assign timeout_err = 1'b0;
`endif

    // Register table: {addr, value}. Entry 0 soft-resets the camera; indices past the table read 0xFFFF.
    always_comb begin
        tbl_entry = 16'hFFFF;
        if (index_q < REG_NUM) begin
            case (index_q)
                8'd0:    tbl_entry = 16'h1280;  // COM7: soft reset
                8'd1:    tbl_entry = 16'h1101;  // CLKRC: prescaler /2
                8'd2:    tbl_entry = 16'h1204;  // COM7: RGB output
                8'd3:    tbl_entry = 16'h0C00;  // COM3: no scaling
                8'd4:    tbl_entry = 16'h3E00;  // COM14: normal PCLK
                8'd5:    tbl_entry = 16'h40D0;  // COM15: RGB565, full range
                8'd6:    tbl_entry = 16'h8C00;  // RGB444 disabled
                8'd7:    tbl_entry = 16'h3A04;  // TSLB: output sequence
                default: tbl_entry = 16'hFFFF;
            endcase
        end
    end

    // The settle delay keys off the data actually sent, so a retried soft reset also waits.
    assign is_soft_rst = (addr_q == 8'h12) && (value_q == 8'h80);

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        value_d = value_q;
        case (state_q)
            // The first edge after release is the entry edge, followed by PWR_DLY_CYC counting cycles.
            S_PWR_WAIT: begin
                if (cnt_q == PWR_DLY_CYC) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                addr_d  = tbl_entry[15:8];
                value_d = tbl_entry[7:0];
                state_d = S_SEND;
            end
            S_SEND: state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (sccb_done) begin
                    state_d = is_soft_rst ? S_RST_WAIT : S_GAP;
                end else if (timeout_hit) begin
                    state_d = S_LOAD;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_NEXT;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (index_q == REG_NUM - 8'd1) begin
                    state_d = S_FINISH;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = S_LOAD;
                end
            end
            S_FINISH: begin
                if (cfg_start) begin
                    index_d = 8'd0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_PWR_WAIT;
        endcase
    end

    // The delay counter restarts from 0 on every state change and only runs in timed states.
    always_comb begin
        cnt_d = 32'd0;
        if (counting && (state_d == state_q)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State, data and registered outputs; the outputs follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWR_WAIT;
            cnt_q   <= 32'd0;
            index_q <= 8'd0;
            addr_q  <= 8'd0;
            value_q <= 8'd0;
            send_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            send_q  <= (state_d == S_SEND);
            busy_q  <= (state_d != S_FINISH);
            done_q  <= (state_d == S_FINISH);
        end
    end

    assign sccb_send_en = send_q;
    assign sccb_addr    = addr_q;
    assign sccb_value   = value_q;
    assign cfg_index    = index_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;

endmodule
